mfm_sync_framer: RTL and testbench

Bit-serial MFM framer between the DPLL data separator and the sector buffer. It hunts the raw MFM cell stream for the 0x4489 (A1) sync word and locks byte alignment after three consecutive syncs. It then validates the address mark and emits decoded mark and field bytes with per-field clock-violation and CRC-16 status. It replaces free-running byte counting downstream of the data separator with sync-aligned framing.

---
 rtl/mfm_pkg.sv | 41 ++++
 rtl/mfm_crc16_serial.sv | 37 +++
 rtl/mfm_sync_framer.sv | 236 +++++++++++++++++++++++
 tb/tb_mfm_sync_framer.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mfm_pkg.sv
// mfm_pkg: shared constants, state encoding and MFM helper functions for
// the MFM sync framer slice (mfm_sync_framer, mfm_crc16_serial).
package mfm_pkg;

  localparam logic [15:0] SYNC_A1         = 16'h4489;
  localparam logic [15:0] SYNC_C2         = 16'h5224;

  localparam logic [7:0]  AM_ID           = 8'hFE;
  localparam logic [7:0]  AM_DATA         = 8'hFB;
  localparam logic [7:0]  AM_DDATA        = 8'hF8;

  localparam logic [15:0] CRC_POLY        = 16'h1021;
  localparam logic [15:0] CRC_PRESET_A1X3 = 16'hCDB4;

  typedef enum logic [1:0] {
    ST_HUNT  = 2'd0,
    ST_SYNC  = 2'd1,
    ST_FIELD = 2'd2
  } framer_state_e;

  // Data bits are the second cell of each clock/data pair.
  function automatic logic [7:0] mfm_decode(input logic [15:0] w);
    logic [7:0] b;
    for (int i = 0; i < 8; i++) begin
      b[i] = w[2*i];
    end
    return b;
  endfunction

  // c[16] is the last data cell of the previous word, c[15:0] the current word.
  // Flags a "11" pair or a missing clock between two zero data cells.
  function automatic logic mfm_clock_violation(input logic [16:0] c);
    logic v;
    v = 1'b0;
    for (int i = 0; i < 8; i++) begin
      v = v | (c[2*i+1] & c[2*i]) | (~c[2*i+2] & ~c[2*i+1] & ~c[2*i]);
    end
    return v;
  endfunction

endpackage

// File: rtl/mfm_crc16_serial.sv
// mfm_crc16_serial: bit-serial CRC-16/CCITT (poly 0x1021), MSB-first.
// Ports:
//   clk, reset  - system clock, asynchronous active-high reset
//   preload     - load the A1 A1 A1 preset (wins over bit_en)
//   bit_en      - shift bit_in into the CRC this cycle
//   bit_in      - data bit
//   crc         - current CRC register
module mfm_crc16_serial
  import mfm_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        preload,
  input  logic        bit_en,
  input  logic        bit_in,
  output logic [15:0] crc
);

  logic [15:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (preload) begin
      crc_d = CRC_PRESET_A1X3;
    end else if (bit_en) begin
      crc_d = {crc_q[14:0], 1'b0} ^ ((crc_q[15] ^ bit_in) ? CRC_POLY : 16'h0000);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) crc_q <= 16'hFFFF;
    else       crc_q <= crc_d;
  end

  assign crc = crc_q;

endmodule

// File: rtl/mfm_sync_framer.sv
// mfm_sync_framer: hunts the raw MFM cell stream for the A1 sync (0x4489),
// locks byte alignment after three consecutive syncs, validates the address
// mark and emits decoded mark/field bytes with clock-violation and CRC status.
// Optional feature macro: MFM_FRAMER_CRC_EN (CRC-16 checking, CRC-gated n_reg).
// Ports:
//   clk, reset         - system clock, asynchronous active-high reset
//   enable             - low forces HUNT and clears field status
//   bit_valid, bit_in  - one MFM cell per strobe, MSB-first
//   byte_out           - decoded byte, qualified by byte_valid
//   byte_valid         - one-cycle byte pulse
//   mark_valid         - byte_valid is the address mark
//   locked             - framer is inside a field
//   field_done         - pulse with the last field byte
//   field_err, crc_ok  - field status, valid with field_done
//   mark_err           - pulse when the post-sync byte is not FE/FB/F8
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_HUNT  | searching every cell for the A1 sync pattern
// ST_SYNC  | aligned; counting A1 words, mark decided on first non-A1 word
// ST_FIELD | emitting field bytes until the length counter runs out
module mfm_sync_framer
  import mfm_pkg::*;
#(
  parameter int MAX_N = 3   // n_reg is 2 bits wide, so MAX_N must be <= 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       bit_valid,
  input  logic       bit_in,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic       mark_valid,
  output logic       locked,
  output logic       field_done,
  output logic       field_err,
  output logic       crc_ok,
  output logic       mark_err
);

  framer_state_e state_q, state_d;
  logic [15:0]   sr_q, sr_d, sr_next;
  logic [3:0]    cell_cnt_q, cell_cnt_d;
  logic [1:0]    sync_cnt_q, sync_cnt_d;
  logic [10:0]   remaining_q, remaining_d;
  logic          err_q, err_d;
  logic          is_id_q, is_id_d;
  logic [1:0]    n_cap_q, n_cap_d;
  logic [1:0]    n_reg_q, n_reg_d;
  logic [7:0]    byte_out_q, byte_out_d;
  logic          byte_valid_q, byte_valid_d;
  logic          mark_valid_q, mark_valid_d;
  logic          field_done_q, field_done_d;
  logic          field_err_q, field_err_d;
  logic          mark_err_q, mark_err_d;

  logic          boundary;
  logic [7:0]    word_byte;
  logic          word_viol;
  logic          crc_good;

  assign sr_next   = bit_valid ? {sr_q[14:0], bit_in} : sr_q;
  assign boundary  = bit_valid && (cell_cnt_q == 4'd15);
  assign word_byte = mfm_decode(sr_next);
  // sr_q[15] is the final data cell of the previous word.
  assign word_viol = mfm_clock_violation({sr_q[15], sr_next});

  always_comb begin
    state_d      = state_q;
    sr_d         = sr_q;
    cell_cnt_d   = cell_cnt_q;
    sync_cnt_d   = sync_cnt_q;
    remaining_d  = remaining_q;
    err_d        = err_q;
    is_id_d      = is_id_q;
    n_cap_d      = n_cap_q;
    n_reg_d      = n_reg_q;
    byte_out_d   = byte_out_q;
    byte_valid_d = 1'b0;
    mark_valid_d = 1'b0;
    field_done_d = 1'b0;
    field_err_d  = 1'b0;
    mark_err_d   = 1'b0;

    if (bit_valid) begin
      sr_d       = sr_next;
      cell_cnt_d = cell_cnt_q + 4'd1;
    end

    if (!enable) begin
      state_d    = ST_HUNT;
      sync_cnt_d = 2'd0;
      err_d      = 1'b0;
    end else begin
      // ID size code is committed once the whole ID field (and its CRC) is in.
      if (field_done_q && is_id_q && crc_good) n_reg_d = n_cap_q;

      case (state_q)
        ST_HUNT: begin
          if (bit_valid && sr_next == SYNC_A1) begin
            state_d    = ST_SYNC;
            sync_cnt_d = 2'd1;
            cell_cnt_d = 4'd0;
          end
        end

        ST_SYNC: begin
          if (boundary) begin
            if (sr_next == SYNC_A1) begin
              if (sync_cnt_q != 2'd3) sync_cnt_d = sync_cnt_q + 2'd1;
            end else if (sync_cnt_q != 2'd3) begin
              state_d    = ST_HUNT;
              sync_cnt_d = 2'd0;
            end else if (word_byte == AM_ID || word_byte == AM_DATA ||
                         word_byte == AM_DDATA) begin
              state_d      = ST_FIELD;
              byte_out_d   = word_byte;
              byte_valid_d = 1'b1;
              mark_valid_d = 1'b1;
              err_d        = 1'b0;
              is_id_d      = (word_byte == AM_ID);
              if (word_byte == AM_ID) remaining_d = 11'd6;
              else                    remaining_d = (11'd128 << n_reg_q) + 11'd2;
            end else begin
              state_d    = ST_HUNT;
              sync_cnt_d = 2'd0;
              mark_err_d = 1'b1;
            end
          end
        end

        ST_FIELD: begin
          if (boundary) begin
            byte_out_d   = word_byte;
            byte_valid_d = 1'b1;
            err_d        = err_q | word_viol;
            remaining_d  = remaining_q - 11'd1;
            // N is the 4th ID byte: C, H, R, N leaves CRC x2 still to come.
            if (is_id_q && remaining_q == 11'd3) begin
              if (int'(word_byte) > MAX_N) n_cap_d = 2'(MAX_N);
              else                         n_cap_d = word_byte[1:0];
            end
            if (remaining_q == 11'd1) begin
              field_done_d = 1'b1;
              field_err_d  = err_q | word_viol;
              state_d      = ST_HUNT;
              sync_cnt_d   = 2'd0;
            end
          end
        end

        default: begin
          state_d    = ST_HUNT;
          sync_cnt_d = 2'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_HUNT;
      sr_q         <= 16'h0000;
      cell_cnt_q   <= 4'd0;
      sync_cnt_q   <= 2'd0;
      remaining_q  <= 11'd0;
      err_q        <= 1'b0;
      is_id_q      <= 1'b0;
      n_cap_q      <= 2'd2;
      n_reg_q      <= 2'd2;
      byte_out_q   <= 8'h00;
      byte_valid_q <= 1'b0;
      mark_valid_q <= 1'b0;
      field_done_q <= 1'b0;
      field_err_q  <= 1'b0;
      mark_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      sr_q         <= sr_d;
      cell_cnt_q   <= cell_cnt_d;
      sync_cnt_q   <= sync_cnt_d;
      remaining_q  <= remaining_d;
      err_q        <= err_d;
      is_id_q      <= is_id_d;
      n_cap_q      <= n_cap_d;
      n_reg_q      <= n_reg_d;
      byte_out_q   <= byte_out_d;
      byte_valid_q <= byte_valid_d;
      mark_valid_q <= mark_valid_d;
      field_done_q <= field_done_d;
      field_err_q  <= field_err_d;
      mark_err_q   <= mark_err_d;
    end
  end

`ifdef MFM_FRAMER_CRC_EN
  logic        crc_preload;
  logic        crc_bit_en;
  logic [15:0] crc;

  // Preset on the A1 that completes (or extends) a run of three, so the CRC
  // covers A1 A1 A1 + mark + field no matter how long the sync run was.
  assign crc_preload = enable && state_q == ST_SYNC && boundary &&
                       sr_next == SYNC_A1 && sync_cnt_q >= 2'd2;
  // Odd cell counts are data cells; the mark word is still seen in ST_SYNC.
  assign crc_bit_en  = enable && bit_valid && cell_cnt_q[0] &&
                       (state_q == ST_FIELD ||
                        (state_q == ST_SYNC && sync_cnt_q == 2'd3));

  mfm_crc16_serial u_crc (
    .clk     (clk),
    .reset   (reset),
    .preload (crc_preload),
    .bit_en  (crc_bit_en),
    .bit_in  (bit_in),
    .crc     (crc)
  );

  // The CRC register already holds the post-last-bit value when field_done is high.
  assign crc_good = (crc == 16'h0000);
  assign crc_ok   = field_done_q & crc_good;
`else
  assign crc_good = 1'b1;
  assign crc_ok   = 1'b0;
`endif

  assign byte_out   = byte_out_q;
  assign byte_valid = byte_valid_q;
  assign mark_valid = mark_valid_q;
  assign field_done = field_done_q;
  assign field_err  = field_err_q;
  assign mark_err   = mark_err_q;
  assign locked     = (state_q == ST_FIELD);

endmodule

// File: tb/tb_mfm_sync_framer.sv
module tb_mfm_sync_framer;
  import mfm_pkg::*;

`ifdef MFM_FRAMER_CRC_EN
  localparam bit CRC_EN = 1'b1;
`else
  localparam bit CRC_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset, enable, bit_valid, bit_in;
  logic [7:0] byte_out;
  logic       byte_valid, mark_valid, locked, field_done, field_err, crc_ok, mark_err;

  mfm_sync_framer #(.MAX_N(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .bit_valid  (bit_valid),
    .bit_in     (bit_in),
    .byte_out   (byte_out),
    .byte_valid (byte_valid),
    .mark_valid (mark_valid),
    .locked     (locked),
    .field_done (field_done),
    .field_err  (field_err),
    .crc_ok     (crc_ok),
    .mark_err   (mark_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] b;
    logic       mark;
    logic       done;
    logic       err;
    logic       ok;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] pl[$];
  int         n_checks = 0;
  int         n_pass = 0;
  int         gap = 2;
  int         mark_err_seen = 0;
  int         mark_err_exp = 0;
  logic       prev_d = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic push_exp(input logic [7:0] b, input logic m, input logic d,
                          input logic e, input logic o);
    exp_t x;
    x.b = b; x.mark = m; x.done = d; x.err = e; x.ok = o;
    exp_q.push_back(x);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a byte.
  initial begin
    forever begin
      @(negedge clk);
      if (mark_err) mark_err_seen++;
      if (byte_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_byte: got %02h with nothing expected at %0t", byte_out, $time);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("byte_out", byte_out, e.b);
          chk("mark_valid", mark_valid, e.mark);
          chk("field_done", field_done, e.done);
          if (e.done) begin
            chk("field_err", field_err, e.err);
            chk("crc_ok", crc_ok, e.ok);
          end
        end
      end else if (mark_valid || field_done) begin
        n_checks++;
        $display("FAIL stray_pulse: mark_valid=%0b field_done=%0b without byte_valid at %0t",
                 mark_valid, field_done, $time);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  function automatic logic [15:0] enc(input logic [7:0] b, input logic p);
    logic [15:0] w;
    logic        pv;
    pv = p;
    for (int i = 7; i >= 0; i--) begin
      w[2*i+1] = ~pv & ~b[i];
      w[2*i]   = b[i];
      pv       = b[i];
    end
    return w;
  endfunction

  function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c;
    for (int i = 7; i >= 0; i--) r = {r[14:0], 1'b0} ^ ((r[15] ^ b[i]) ? CRC_POLY : 16'h0000);
    return r;
  endfunction

  task automatic send_cell(input logic b);
    bit_in = b;
    bit_valid = 1'b1;
    @(posedge clk); #1;
    bit_valid = 1'b0;
    repeat (gap - 1) begin @(posedge clk); #1; end
  endtask

  task automatic send_word(input logic [15:0] w, input int n);
    for (int i = 15; i > 15 - n; i--) send_cell(w[i]);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit inj);
    logic [15:0] w;
    bit          done;
    w = enc(b, prev_d);
    done = 1'b0;
    if (inj) begin
      for (int i = 0; i < 8; i++) begin
        if (!done && w[2*i]) begin
          w[2*i+1] = 1'b1;
          done = 1'b1;
        end
      end
    end
    send_word(w, 16);
    prev_d = b[0];
  endtask

  task automatic send_sync();
    send_word(SYNC_A1, 16);
    prev_d = 1'b1;
  endtask

  task automatic filler(input int n);
    repeat (n) send_byte(8'h4E, 1'b0);
  endtask

  task automatic add_crc(input logic [7:0] mark);
    logic [15:0] c;
    c = crc_upd(CRC_PRESET_A1X3, mark);
    foreach (pl[i]) c = crc_upd(c, pl[i]);
    pl.push_back(c[15:8]);
    pl.push_back(c[7:0]);
  endtask

  task automatic make_id(input logic [7:0] n);
    pl.delete();
    pl.push_back(8'h00); pl.push_back(8'h00); pl.push_back(8'h01); pl.push_back(n);
    add_crc(AM_ID);
  endtask

  task automatic send_frame(input int nsync, input logic [7:0] mark, input int inj_idx,
                            input logic exp_err, input logic exp_ok);
    filler(4);
    repeat (nsync) send_sync();
    push_exp(mark, 1'b1, 1'b0, 1'b0, 1'b0);
    send_byte(mark, 1'b0);
    chk("locked_in_field", locked, 1'b1);
    foreach (pl[i]) begin
      push_exp(pl[i], 1'b0, (i == pl.size() - 1), exp_err, exp_ok);
      send_byte(pl[i], (i == inj_idx));
    end
    filler(2);
    chk("locked_after_field", locked, 1'b0);
    chk("queue_drained", exp_q.size(), 0);
  endtask

  // Frame that is cut off during the 3rd payload byte; use_reset selects the abort kind.
  task automatic send_aborted(input bit use_reset);
    logic [15:0] w;
    make_id(8'h02);
    filler(4);
    repeat (3) send_sync();
    push_exp(AM_ID, 1'b1, 1'b0, 1'b0, 1'b0);
    send_byte(AM_ID, 1'b0);
    push_exp(pl[0], 1'b0, 1'b0, 1'b0, 1'b0);
    send_byte(pl[0], 1'b0);
    push_exp(pl[1], 1'b0, 1'b0, 1'b0, 1'b0);
    send_byte(pl[1], 1'b0);
    w = enc(pl[2], prev_d);
    if (use_reset) begin
      send_word(w, 8);
      chk("locked_before_reset", locked, 1'b1);
      #2 reset = 1'b1;
      #1;
      chk("locked_async_reset", locked, 1'b0);
      chk("byte_out_async_reset", byte_out, 8'h00);
      repeat (2) begin @(posedge clk); #1; end
      reset = 1'b0;
      prev_d = 1'b0;
    end else begin
      send_word(w, 15);
      enable = 1'b0;
      send_cell(w[0]);
      prev_d = pl[2][0];
      chk("locked_enable_drop", locked, 1'b0);
      send_byte(pl[3], 1'b0);
      send_byte(pl[4], 1'b0);
      send_byte(pl[5], 1'b0);
      enable = 1'b1;
    end
    repeat (4) begin @(posedge clk); #1; end
    chk("queue_drained_abort", exp_q.size(), 0);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; bit_valid = 1'b0; bit_in = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_byte_out", byte_out, 8'h00);
    chk("rst_byte_valid", byte_valid, 1'b0);
    chk("rst_mark_valid", mark_valid, 1'b0);
    chk("rst_locked", locked, 1'b0);
    chk("rst_field_done", field_done, 1'b0);
    chk("rst_field_err", field_err, 1'b0);
    chk("rst_crc_ok", crc_ok, 1'b0);
    chk("rst_mark_err", mark_err, 1'b0);
    @(posedge clk); #1;

    // Clean ID field, N=2.
    make_id(8'h02);
    send_frame(3, AM_ID, -1, 1'b0, CRC_EN);

    // Corrupted N byte: CRC fails, n_reg only moves when CRC checking is off.
    make_id(8'h02);
    pl[3] = 8'h03;
    send_frame(3, AM_ID, -1, 1'b0, 1'b0);
    pl.delete();
    for (int i = 0; i < (CRC_EN ? 512 : 1024); i++) pl.push_back(8'(i));
    add_crc(AM_DATA);
    send_frame(3, AM_DATA, -1, 1'b0, CRC_EN);

    // N=0 ID then 128-byte data field, back-to-back cells.
    gap = 1;
    make_id(8'h00);
    send_frame(3, AM_ID, -1, 1'b0, CRC_EN);
    pl.delete();
    repeat (128) pl.push_back(8'hE5);
    add_crc(AM_DATA);
    send_frame(3, AM_DATA, -1, 1'b0, CRC_EN);
    gap = 2;

    // Short sync run, then bad mark.
    filler(4);
    send_sync(); send_sync();
    send_byte(8'h4E, 1'b0);
    filler(4);
    chk("locked_short_sync", locked, 1'b0);
    repeat (3) send_sync();
    send_byte(8'hC7, 1'b0);
    mark_err_exp++;
    filler(2);
    chk("mark_err_count", mark_err_seen, mark_err_exp);
    chk("locked_bad_mark", locked, 1'b0);

    // Four syncs, ID with an injected 11 pair in R.
    make_id(8'h02);
    send_frame(4, AM_ID, 2, 1'b1, CRC_EN);

    // Asynchronous reset mid-field, then a clean ID.
    send_aborted(1'b1);
    make_id(8'h02);
    send_frame(3, AM_ID, -1, 1'b0, CRC_EN);

    // enable drop on the 3rd payload byte boundary, then a clean ID.
    send_aborted(1'b0);
    make_id(8'h02);
    send_frame(3, AM_ID, -1, 1'b0, CRC_EN);

    repeat (10) @(posedge clk);
    chk("final_queue_empty", exp_q.size(), 0);
    chk("final_mark_err_count", mark_err_seen, mark_err_exp);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
